// File: rtl/ro_pair_scheduler.sv
// Ring-oscillator PUF pair scheduler: settle, count both ROs, compare.
// Optional ROPUF_SEL_CHECK_EN rejects challenges with equal A/B selects.
`timescale 1ns/1ps
module ro_pair_scheduler #(
    parameter int WINDOW        = 256,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] challenge,
    input  logic       ro_a,
    input  logic       ro_b,
    output logic [3:0] sel_a,
    output logic [3:0] sel_b,
    output logic       busy,
    output logic       done,
    output logic       response,
    output logic       tie,
    output logic       err
);

    localparam int TMAX = (WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] W_LAST = TW'(WINDOW - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic             edge_a;
    logic             edge_b;

    assign edge_a = sync_a[1] & ~sync_a[2];
    assign edge_b = sync_b[1] & ~sync_b[2];

    // Two-flop synchronizers plus an edge-history flop, always running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], ro_a};
            sync_b <= {sync_b[1:0], ro_b};
        end
    end

`ifndef ROPUF_SEL_CHECK_EN
    assign err = 1'b0;
`endif

    // Measurement sequencer with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            sel_a    <= '0;
            sel_b    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= 1'b0;
            tie      <= 1'b0;
`ifdef ROPUF_SEL_CHECK_EN
            err      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_a    <= challenge[7:4];
                        sel_b    <= challenge[3:0];
                        cnt_a    <= '0;
                        cnt_b    <= '0;
                        response <= 1'b0;
                        tie      <= 1'b0;
                        timer    <= '0;
                        busy     <= 1'b1;
`ifdef ROPUF_SEL_CHECK_EN
                        err      <= (challenge[7:4] == challenge[3:0]);
                        if (challenge[7:4] == challenge[3:0]) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
`else
                        state    <= SETTLE;
`endif
                    end
                end
                SETTLE: begin
                    if (timer == S_LAST) begin
                        timer <= '0;
                        state <= COUNT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                COUNT: begin
                    if (edge_a && cnt_a != '1)
                        cnt_a <= cnt_a + CNT_W'(1);
                    if (edge_b && cnt_b != '1)
                        cnt_b <= cnt_b + CNT_W'(1);
                    if (timer == W_LAST) begin
                        timer <= '0;
                        state <= COMPARE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                COMPARE: begin
                    response <= (cnt_a > cnt_b);
                    tie      <= (cnt_a == cnt_b);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_pair_scheduler.sv
// Directed bench for ro_pair_scheduler with a response scoreboard.
// A second instance with CNT_W=4 exercises counter saturation.
`timescale 1ns/1ps
module tb_ro_pair_scheduler;

    typedef struct packed {
        logic resp;
        logic tie;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start4;
    logic [7:0] challenge, challenge4;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;
    int         pa = 4;
    int         pb = 6;

    logic [3:0] sel_a, sel_b, sel_a4, sel_b4;
    logic       busy, done, response, tie, err;
    logic       busy4, done4, response4, tie4, err4;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ro_pair_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b),
        .busy(busy), .done(done), .response(response), .tie(tie),
        .err(err)
    );

    ro_pair_scheduler #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .challenge(challenge4),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a4), .sel_b(sel_b4),
        .busy(busy4), .done(done4), .response(response4), .tie(tie4),
        .err(err4)
    );

    always #5 clk = ~clk;

    // RO models: toggle every half period, offset from clock edges
    initial begin
        #2;
        forever #(pa * 5) ro_a = ~ro_a;
    end
    initial begin
        #2;
        forever #(pb * 5) ro_b = ~ro_b;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int act, input int at, output int lat);
        lat = -1;
        if (done) lat = 0;
        for (int j = 1; j <= 400 && lat == -1; j++) begin
            @(negedge clk);
            if (act == 1 && j == at) begin
                start = 1'b1;
                challenge = 8'hFF;
            end
            if (act == 1 && j == at + 1) start = 1'b0;
            if (act == 2 && j == at) begin
                rst_n = 1'b0;
                #1;
                lat = -2;
                break;
            end
            if (done) lat = j;
        end
    endtask

    task automatic run(input logic [7:0] ch, input int act, input int at,
                       output int lat);
        challenge = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("sel_a_latch", sel_a, ch[7:4]);
        check("sel_b_latch", sel_b, ch[3:0]);
        check("busy_on", busy, 1'b1);
        wait_done(act, at, lat);
    endtask

    task automatic finish_meas(input int lat, input int exp_lat);
        exp_t e;
        check("latency", lat, exp_lat);
        e = sb.pop_front();
        check("response", response, e.resp);
        check("tie", tie, e.tie);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("busy_off", busy, 1'b0);
        check("response_hold", response, e.resp);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        start4 = 1'b0;
        challenge = 8'h00;
        challenge4 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_resp", response, 1'b0);
        check("rst_tie", tie, 1'b0);
        check("rst_sel", {sel_a, sel_b}, 8'h00);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A faster than B
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        run(8'h3A, 0, 0, lat);
        check("cnt_a_range", (dut.cnt_a >= 63 && dut.cnt_a <= 65), 1'b1);
        check("cnt_b_range", (dut.cnt_b >= 41 && dut.cnt_b <= 44), 1'b1);
        finish_meas(lat, 273);

        // B faster than A
        pa = 6;
        pb = 4;
        repeat (10) @(negedge clk);
        sb.push_back('{resp: 1'b0, tie: 1'b0});
        run(8'hC5, 0, 0, lat);
        finish_meas(lat, 273);

        // Saturation on the narrow-counter instance
        pa = 4;
        pb = 4;
        repeat (10) @(negedge clk);
        sb.push_back('{resp: 1'b0, tie: 1'b1});
        challenge4 = 8'h3A;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = -1;
        for (int j = 1; j <= 400 && lat == -1; j++) begin
            @(negedge clk);
            if (done4) lat = j;
        end
        check("sat_latency", lat, 273);
        check("sat_cnt_a", dut4.cnt_a, 4'hF);
        check("sat_cnt_b", dut4.cnt_b, 4'hF);
        begin
            exp_t e;
            e = sb.pop_front();
            check("sat_response", response4, e.resp);
            check("sat_tie", tie4, e.tie);
        end

        // Start pulsed mid-COUNT with a new challenge is ignored
        pa = 4;
        pb = 6;
        repeat (10) @(negedge clk);
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        run(8'h21, 1, 100, lat);
        check("busy_sel_a", sel_a, 4'h2);
        check("busy_sel_b", sel_b, 4'h1);
        finish_meas(lat, 273);
        repeat (5) @(negedge clk);
        check("no_requeue_busy", busy, 1'b0);
        check("no_requeue_done", done, 1'b0);
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        run(8'h47, 0, 0, lat);
        finish_meas(lat, 273);

        // Reset mid-COUNT aborts
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        run(8'h3A, 2, 150, lat);
        void'(sb.pop_front());
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sel", {sel_a, sel_b}, 8'h00);
        check("abort_resp", {response, tie}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        run(8'h3A, 0, 0, lat);
        finish_meas(lat, 273);

        // Start held high restarts on first IDLE edge after DONE
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        challenge = 8'h3A;
        start = 1'b1;
        @(negedge clk);
        wait_done(0, 0, lat);
        finish_meas(lat, 273);
        @(negedge clk);
        check("held_restart", busy, 1'b1);
        start = 1'b0;
        wait_done(0, 0, lat);
        finish_meas(lat, 273);

        // Equal selects
`ifdef ROPUF_SEL_CHECK_EN
        sb.push_back('{resp: 1'b0, tie: 1'b0});
        run(8'h55, 0, 0, lat);
        check("eq_err", err, 1'b1);
        finish_meas(lat, 0);
`else
        sb.push_back('{resp: 1'b0, tie: 1'b1});
        pa = 4;
        pb = 4;
        void'(sb.pop_back());
        pa = 4;
        pb = 6;
        repeat (10) @(negedge clk);
        sb.push_back('{resp: 1'b1, tie: 1'b0});
        run(8'h55, 0, 0, lat);
        check("eq_err", err, 1'b0);
        finish_meas(lat, 273);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
